// File: rtl/lbp_stream.sv
// ----------------------------------------------------------------------------
// lbp_stream
//   Streaming 3x3 Local Binary Pattern engine. Reads a grey image in raster
//   order from host pixel memory, keeps two line buffers plus a small column
//   window, and writes one 8-bit LBP code per interior pixel to result memory.
//   Returns to IDLE after every frame, so frames can be repeated.
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   gray_ready  in   host image available / not paused
//   gray_req    out  pixel read request, address on gray_addr
//   gray_addr   out  pixel read address = row*IMG_W + col
//   gray_data   in   pixel data, valid the cycle after gray_req
//   lbp_valid   out  result write strobe
//   lbp_addr    out  result address = centre row*IMG_W + col
//   lbp_data    out  LBP code
//   finish      out  one-cycle pulse when the frame is complete
// ----------------------------------------------------------------------------
module lbp_stream #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14,
    parameter int CMP_GE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [PIX_W-1:0]  gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] CTR_OFFSET = ADDR_W'(IMG_W + 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state;
    logic [COL_W-1:0]  req_col;
    logic [ROW_W-1:0]  req_row;

    // Position of the pixel arriving on gray_data this cycle.
    logic              cap_vld;
    logic [ADDR_W-1:0] cap_addr;
    logic [COL_W-1:0]  cap_col;
    logic [ROW_W-1:0]  cap_row;

    // lb_top holds row r-1, lb_mid holds row r, both indexed by column.
    logic [PIX_W-1:0]  lb_top [IMG_W];
    logic [PIX_W-1:0]  lb_mid [IMG_W];

    // Columns c-1 ([*][0]) and c ([*][1]); column c+1 is the incoming one
    // (line-buffer reads plus gray_data), so it needs no register.
    logic [PIX_W-1:0]  win [3][2];

    logic [PIX_W-1:0]  top_col;
    logic [PIX_W-1:0]  mid_col;
    logic [7:0]        code;

    function automatic logic nbr_bit(input logic [PIX_W-1:0] nbr,
                                     input logic [PIX_W-1:0] ctr);
        return (CMP_GE != 0) ? (nbr >= ctr) : (nbr > ctr);
    endfunction

    // Requests follow gray_ready in the same cycle, so a pause suppresses
    // the request immediately while the address register simply holds.
    assign gray_req = (state == FETCH) && gray_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gray_addr <= '0;
            req_col   <= '0;
            req_row   <= '0;
            finish    <= 1'b0;
            cap_vld   <= 1'b0;
            cap_addr  <= '0;
            cap_col   <= '0;
            cap_row   <= '0;
        end else begin
            finish  <= 1'b0;
            cap_vld <= gray_req;
            if (gray_req) begin
                cap_addr <= gray_addr;
                cap_col  <= req_col;
                cap_row  <= req_row;
            end

            case (state)
                IDLE: begin
                    if (gray_ready) state <= FETCH;
                end
                FETCH: begin
                    if (gray_req) begin
                        if (gray_addr == LAST_ADDR) begin
                            // Counters rewind here so the next frame starts at 0.
                            state     <= DRAIN;
                            gray_addr <= '0;
                            req_col   <= '0;
                            req_row   <= '0;
                        end else begin
                            gray_addr <= gray_addr + 1'b1;
                            if (req_col == LAST_COL) begin
                                req_col <= '0;
                                req_row <= req_row + 1'b1;
                            end else begin
                                req_col <= req_col + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // The last pixel is captured while cap_vld is high; its code
                    // is on the outputs the cycle after, when cap_vld has dropped.
                    if (!cap_vld) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: line buffers and window are pure data storage; every entry is
    // written before it is used for an emitted code, so they carry no reset.
    always_ff @(posedge clk) begin
        if (cap_vld) begin
            lb_top[cap_col] <= lb_mid[cap_col];
            lb_mid[cap_col] <= gray_data;
            for (int r = 0; r < 3; r++) win[r][0] <= win[r][1];
            win[0][1] <= top_col;
            win[1][1] <= mid_col;
            win[2][1] <= gray_data;
        end
    end

    // NOTE: every always_comb output is assigned on all paths so no latch forms.
    always_comb begin
        top_col = lb_top[cap_col];
        mid_col = lb_mid[cap_col];
        code[0] = nbr_bit(win[0][0], win[1][1]);
        code[1] = nbr_bit(win[0][1], win[1][1]);
        code[2] = nbr_bit(top_col,   win[1][1]);
        code[3] = nbr_bit(win[1][0], win[1][1]);
        code[4] = nbr_bit(mid_col,   win[1][1]);
        code[5] = nbr_bit(win[2][0], win[1][1]);
        code[6] = nbr_bit(win[2][1], win[1][1]);
        code[7] = nbr_bit(gray_data, win[1][1]);
    end

    // Only captures at row>=2, col>=2 complete a window whose centre is
    // interior; wrap columns 0 and 1 never qualify, so rows are never mixed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
        end else begin
            lbp_valid <= 1'b0;
            if (cap_vld && cap_row >= ROW_W'(2) && cap_col >= COL_W'(2)) begin
                lbp_valid <= 1'b1;
                lbp_addr  <= cap_addr - CTR_OFFSET;
                lbp_data  <= code;
            end
        end
    end

endmodule

// File: tb/tb_lbp_stream.sv
module tb_lbp_stream;

    localparam int AW = 7;
    localparam int AH = 5;
    localparam int AN = AW * AH;
    localparam int BW = 3;
    localparam int BH = 3;
    localparam int BN = BW * BH;

    typedef struct {
        int addr;
        int code;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance A: 7x5, compare >=
    logic       a_ready, a_req, a_valid, a_finish;
    logic [5:0] a_addr, a_laddr;
    logic [7:0] a_gdata, a_ldata;
    // Instance B: 3x3, compare >
    logic       b_ready, b_req, b_valid, b_finish;
    logic [3:0] b_addr, b_laddr;
    logic [7:0] b_gdata, b_ldata;

    lbp_stream #(.IMG_W(AW), .IMG_H(AH), .PIX_W(8), .ADDR_W(6), .CMP_GE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .gray_ready(a_ready), .gray_req(a_req),
        .gray_addr(a_addr), .gray_data(a_gdata), .lbp_valid(a_valid),
        .lbp_addr(a_laddr), .lbp_data(a_ldata), .finish(a_finish));

    lbp_stream #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8), .ADDR_W(4), .CMP_GE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .gray_ready(b_ready), .gray_req(b_req),
        .gray_addr(b_addr), .gray_data(b_gdata), .lbp_valid(b_valid),
        .lbp_addr(b_laddr), .lbp_data(b_ldata), .finish(b_finish));

    logic [7:0] img_a [AN];
    logic [7:0] img_b [BN];

    // Host pixel memories: data returned the cycle after the request.
    initial begin
        a_gdata = '0;
        b_gdata = '0;
    end
    always @(posedge clk) if (a_req && int'(a_addr) < AN) a_gdata <= img_a[a_addr];
    always @(posedge clk) if (b_req && int'(b_addr) < BN) b_gdata <= img_b[b_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    exp_t q_a[$];
    exp_t q_b[$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- monitors ----------------
    int         a_next = 0;
    int         a_fin_cnt = 0;
    int         a_req_cyc [AN];
    logic [5:0] a_last_addr = '0;
    logic [7:0] a_last_data = '0;

    always @(negedge clk) begin
        exp_t e;
        int   ri;
        if (reset_n) begin
            if (a_req) begin
                check("a_req_without_ready", int'(a_ready), 1);
                check("a_req_addr", int'(a_addr), a_next);
                if (int'(a_addr) < AN) a_req_cyc[a_addr] = cyc;
                a_next++;
            end
            if (a_valid) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_strobe", int'(a_laddr), -1);
                end else begin
                    e = q_a.pop_front();
                    check("a_lbp_addr", int'(a_laddr), e.addr);
                    check("a_lbp_data", int'(a_ldata), e.code);
                    ri = int'(a_laddr) + AW + 1;
                    if (ri < AN) check("a_latency", cyc - a_req_cyc[ri], 2);
                    else check("a_latency_index", ri, AN - 1);
                end
                a_last_addr = a_laddr;
                a_last_data = a_ldata;
            end else begin
                check("a_hold_addr", int'(a_laddr), int'(a_last_addr));
                check("a_hold_data", int'(a_ldata), int'(a_last_data));
            end
            if (a_finish) begin
                a_fin_cnt++;
                a_next = 0;
            end
        end
    end

    int b_next = 0;
    int b_fin_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (b_req) begin
                check("b_req_addr", int'(b_addr), b_next);
                b_next++;
            end
            if (b_valid) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_strobe", int'(b_laddr), -1);
                end else begin
                    e = q_b.pop_front();
                    check("b_lbp_addr", int'(b_laddr), e.addr);
                    check("b_lbp_data", int'(b_ldata), e.code);
                end
            end
            if (b_finish) begin
                b_fin_cnt++;
                b_next = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_a(input int addr, input int code);
        exp_t e;
        e.addr = addr;
        e.code = code;
        q_a.push_back(e);
    endtask

    // Straightforward 2-D reference for image A (compare >=).
    task automatic push_model_a();
        int dr [8];
        int dc [8];
        int ctr, nbr, code;
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        for (int r = 1; r <= AH - 2; r++) begin
            for (int c = 1; c <= AW - 2; c++) begin
                ctr  = int'(img_a[r * AW + c]);
                code = 0;
                for (int k = 0; k < 8; k++) begin
                    nbr = int'(img_a[(r + dr[k]) * AW + c + dc[k]]);
                    if (nbr >= ctr) code += (1 << k);
                end
                push_a(r * AW + c, code);
            end
        end
    endtask

    task automatic run_a(input int pause_pct, input int frames);
        int seen = 0;
        int budget = 0;
        while (seen < frames && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (a_finish) seen++;
            if (seen >= frames) a_ready = 1'b0;
            else a_ready = (int'($urandom_range(99)) >= pause_pct);
        end
        a_ready = 1'b0;
        check("a_frames_finished", seen, frames);
        @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
    endtask

    task automatic run_b(input int addr, input int code);
        exp_t e;
        int   budget = 0;
        e.addr = addr;
        e.code = code;
        q_b.push_back(e);
        b_ready = 1'b1;
        while (!b_finish && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        b_ready = 1'b0;
        check("b_frame_finished", int'(b_finish), 1);
        @(negedge clk);
        check("b_queue_drained", q_b.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int budget;
        reset_n = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a_req",   int'(a_req), 0);
        check("rst_a_addr",  int'(a_addr), 0);
        check("rst_a_valid", int'(a_valid), 0);
        check("rst_a_laddr", int'(a_laddr), 0);
        check("rst_a_ldata", int'(a_ldata), 0);
        check("rst_a_finish", int'(a_finish), 0);
        check("rst_b_valid", int'(b_valid), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // B: ramp 10..90, centre 50, b4..b7 larger -> 0xF0
        for (int i = 0; i < BN; i++) img_b[i] = 8'((i + 1) * 10);
        run_b(4, 8'hF0);
        // B: constant image with strict compare -> 0x00
        for (int i = 0; i < BN; i++) img_b[i] = 8'd7;
        run_b(4, 8'h00);
        // B: ties with centre 5; only b3 (6) and b6 (9) exceed -> 0x48
        img_b = '{8'd5, 8'd5, 8'd4, 8'd6, 8'd5, 8'd5, 8'd4, 8'd9, 8'd5};
        run_b(4, 8'h48);

        // A: checkerboard. Diagonals share the centre colour, so with >=
        // a 255 centre sets b0,b2,b5,b7 (0xA5); a 0 centre sets all (0xFF).
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++)
                img_a[r * AW + c] = ((r + c) % 2 == 0) ? 8'd255 : 8'd0;
        for (int r = 1; r <= AH - 2; r++)
            for (int c = 1; c <= AW - 2; c++)
                push_a(r * AW + c, ((r + c) % 2 == 0) ? 8'hA5 : 8'hFF);
        run_a(0, 1);

        // A: constant 0x55 -> every interior code 0xFF
        for (int i = 0; i < AN; i++) img_a[i] = 8'h55;
        for (int r = 1; r <= AH - 2; r++)
            for (int c = 1; c <= AW - 2; c++)
                push_a(r * AW + c, 8'hFF);
        run_a(0, 1);

        // A: random images with ~30% pauses (small range forces ties)
        for (int i = 0; i < AN; i++) img_a[i] = 8'($urandom_range(3));
        push_model_a();
        run_a(30, 1);
        for (int i = 0; i < AN; i++) img_a[i] = 8'($urandom_range(255));
        push_model_a();
        run_a(30, 1);

        // A: reset mid-frame, then a clean frame from address 0
        push_model_a();
        a_ready = 1'b1;
        budget  = 0;
        while (int'(a_addr) != 17 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("a_reached_abort_addr", int'(a_addr), 17);
        #2 reset_n = 1'b0;
        #1;
        check("abort_a_req",    int'(a_req), 0);
        check("abort_a_addr",   int'(a_addr), 0);
        check("abort_a_valid",  int'(a_valid), 0);
        check("abort_a_laddr",  int'(a_laddr), 0);
        check("abort_a_ldata",  int'(a_ldata), 0);
        check("abort_a_finish", int'(a_finish), 0);
        q_a.delete();
        a_next      = 0;
        a_last_addr = '0;
        a_last_data = '0;
        a_ready     = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < AN; i++) img_a[i] = 8'($urandom_range(255));
        push_model_a();
        run_a(0, 1);

        // A: two back-to-back frames with gray_ready held high
        for (int i = 0; i < AN; i++) img_a[i] = 8'($urandom_range(15));
        push_model_a();
        push_model_a();
        run_a(0, 2);

        repeat (3) @(negedge clk);
        check("a_finish_pulses_total", a_fin_cnt, 7);
        check("b_finish_pulses_total", b_fin_cnt, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
